// File: rtl/freq_div_pkg.sv
// Shared types and constants for the freq_div_ctrl tick scheduler.
package freq_div_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_PEND = 2'd2
   } chan_state_e;

   localparam int PRE_DIV_DEFAULT = 1000;

   // A divisor of 0 is meaningless for a tick period, so it is treated as 1.
   function automatic logic [31:0] div_at_least_one(input logic [31:0] div);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One scheduler channel: divides the shared base tick by a programmable ratio.
// Divisor updates on a running channel wait for the current period to finish.
// Optional divided-clock output is built when FREQ_DIV_CTRL_CLKOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | channel stopped, counter held at 0, no ticks
// S_RUN   | counting base ticks against div, tick on each wrap
// S_PEND  | counting with old div; shadow is loaded into div at the wrap
module freq_div_chan
   import freq_div_pkg::*;
#(
   parameter int DIV_W = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             base_tick,
   input  logic             load,
   input  logic             cfg_en,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             tick,
   output logic             active,
   output logic             pending
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
   ,
   output logic             clk_div
`endif
);

   localparam logic [1:0] S_IDLE = 2'(CH_IDLE);
   localparam logic [1:0] S_RUN  = 2'(CH_RUN);
   localparam logic [1:0] S_PEND = 2'(CH_PEND);

   logic [1:0]       state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] cfg_div_eff;
   logic             wrap;

   assign cfg_div_eff = DIV_W'(div_at_least_one(32'(cfg_div)));

   // div is never 0, so div-1 cannot underflow and cnt never exceeds div-1.
   assign wrap    = base_tick && (state != S_IDLE) && (cnt == div - DIV_W'(1));
   assign active  = (state != S_IDLE);
   assign pending = (state == S_PEND);

   // Channel FSM, period counter, divisor/shadow registers and tick pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         div    <= DIV_W'(1);
         shadow <= DIV_W'(1);
         tick   <= 1'b0;
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
         clk_div <= 1'b0;
`endif
      end else begin
         tick <= wrap;
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
         if (wrap) begin
            clk_div <= ~clk_div;
         end
`endif
         case (state)
            S_IDLE: begin
               if (load && cfg_en) begin
                  div   <= cfg_div_eff;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (base_tick) begin
                  cnt <= wrap ? '0 : cnt + DIV_W'(1);
               end
               // A wrap on the same cycle as the update still completes with the old div.
               if (load) begin
                  if (cfg_en) begin
                     shadow <= cfg_div_eff;
                     state  <= S_PEND;
                  end else begin
                     cnt   <= '0;
                     state <= S_IDLE;
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
                     clk_div <= 1'b0;
`endif
                  end
               end
            end
            S_PEND: begin
               if (base_tick) begin
                  cnt <= wrap ? '0 : cnt + DIV_W'(1);
               end
               if (wrap) begin
                  div   <= shadow;
                  state <= S_RUN;
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/freq_div_ctrl.sv
// Multi-channel tick scheduler: one shared base prescaler feeding NCH
// independently programmable channel dividers, configured over valid/ready.
// Define FREQ_DIV_CTRL_CLKOUT_EN to add the per-channel clk_div output.
module freq_div_ctrl
   import freq_div_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DIV_W   = 16,
   parameter int PRE_DIV = PRE_DIV_DEFAULT
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [$clog2(NCH)-1:0] cfg_ch,
   input  logic                   cfg_en,
   input  logic [DIV_W-1:0]       cfg_div,
   output logic [NCH-1:0]         tick,
   output logic [NCH-1:0]         active,
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
   output logic [NCH-1:0]         clk_div,
`endif
   output logic [NCH-1:0]         pending
);

   localparam int CHW = $clog2(NCH);
   localparam int PW  = $clog2(PRE_DIV);

   logic [PW-1:0] pre_cnt;
   logic          base_tick;
   logic          accept;

   assign base_tick = (pre_cnt == PW'(PRE_DIV - 1));

   // Free-running base prescaler; channel activity never disturbs its phase.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= base_tick ? '0 : pre_cnt + PW'(1);
      end
   end

   // A channel waiting for its period boundary holds off further requests to it.
   assign cfg_ready = !pending[cfg_ch];
   assign accept    = cfg_valid && cfg_ready;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic load;

      assign load = accept && (cfg_ch == CHW'(i));

      freq_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .base_tick (base_tick),
         .load      (load),
         .cfg_en    (cfg_en),
         .cfg_div   (cfg_div),
         .tick      (tick[i]),
         .active    (active[i]),
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
         .clk_div   (clk_div[i]),
`endif
         .pending   (pending[i])
      );
   end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios plus random configuration
// traffic, checked against an event-time reference model via a tick scoreboard.
module tb_freq_div_ctrl;

   localparam int NCH   = 4;
   localparam int DIV_W = 16;
   localparam int P     = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_ch;
   logic             cfg_en;
   logic [DIV_W-1:0] cfg_div;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   active;
   logic [NCH-1:0]   pending;
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
   logic [NCH-1:0]   clk_div;
`endif

   freq_div_ctrl #(
      .NCH     (NCH),
      .DIV_W   (DIV_W),
      .PRE_DIV (P)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_en    (cfg_en),
      .cfg_div   (cfg_div),
      .tick      (tick),
      .active    (active),
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
      .clk_div   (clk_div),
`endif
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Reference model: each running channel keeps the absolute index (edges
   // since reset release) of its next wrap. Base ticks sit on edges n with
   // n % P == P-1; a period of d base ticks spans d*P edges.
   typedef struct packed {
      int         e;
      logic [1:0] ch;
   } exp_t;

   exp_t tq[$];
   bit   m_on[NCH];
   bit   m_pend[NCH];
   bit   m_clk[NCH];
   int   m_div[NCH];
   int   m_shadow[NCH];
   int   m_next[NCH];
   int   n        = 0;
   int   edge_cnt = 0;
   int   total    = 0;
   int   bad      = 0;

   function automatic void model_edge(input int r, input int v, input int ch,
                                      input int en, input int dv);
      bit acc;
      int d;
      int b1;
      edge_cnt++;
      if (r == 0) begin
         for (int i = 0; i < NCH; i++) begin
            m_on[i]   = 1'b0;
            m_pend[i] = 1'b0;
            m_clk[i]  = 1'b0;
         end
         tq.delete();
         n = 0;
         return;
      end
      acc = (v != 0) && !m_pend[ch];
      for (int i = 0; i < NCH; i++) begin
         if (m_on[i] && m_next[i] == n) begin
            tq.push_back('{e: edge_cnt, ch: 2'(i)});
            m_clk[i] = !m_clk[i];
            if (m_pend[i]) begin
               m_div[i]  = m_shadow[i];
               m_pend[i] = 1'b0;
            end
            m_next[i] = n + m_div[i] * P;
         end
      end
      if (acc) begin
         d = (dv == 0) ? 1 : dv;
         if (en == 0) begin
            m_on[ch]   = 1'b0;
            m_pend[ch] = 1'b0;
            m_clk[ch]  = 1'b0;
         end else if (!m_on[ch]) begin
            m_on[ch]   = 1'b1;
            m_div[ch]  = d;
            b1         = n + 1 + (P - 1 - ((n + 1) % P));
            m_next[ch] = b1 + (d - 1) * P;
         end else begin
            m_pend[ch]   = 1'b1;
            m_shadow[ch] = d;
         end
      end
      n++;
   endfunction

   // One clock: drive inputs at negedge, check cfg_ready, advance model at posedge.
   task automatic step(input int r, input int v, input int ch, input int en, input int dv);
      logic want_rdy;
      @(negedge clk);
      reset     = (r != 0);
      cfg_valid = (v != 0);
      cfg_ch    = 2'(ch);
      cfg_en    = (en != 0);
      cfg_div   = 16'(dv);
      #1;
      want_rdy = m_pend[ch] ? 1'b0 : 1'b1;
      total++;
      if (cfg_ready !== want_rdy) begin
         bad++;
         $display("FAIL cfg_ready ch%0d edge %0d: got %b want %b", ch, edge_cnt, cfg_ready, want_rdy);
      end
      @(posedge clk);
      model_edge(r, v, ch, en, dv);
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) step(1, 0, 0, 0, 0);
   endtask

   // Hold a request valid until the channel can take it.
   task automatic send(input int ch, input int en, input int dv);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         done = !m_pend[ch];
         step(1, 1, ch, en, dv);
      end
      if (!done) begin
         bad++;
         total++;
         $display("FAIL send_timeout ch%0d: got stalled want accepted", ch);
      end
   endtask

   // Advance until the coming edge is the given channel's wrap edge.
   task automatic wait_wrap(input int ch);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
         if (m_on[ch] && m_next[ch] == n) hit = 1'b1;
         else idle(1);
      end
      if (!hit) begin
         bad++;
         total++;
         $display("FAIL wrap_timeout ch%0d: got no wrap want wrap", ch);
      end
   endtask

   // Scoreboard monitor: collects expected ticks for the edge just taken and
   // compares them, plus active/pending, every cycle.
   always @(negedge clk) begin
      logic [NCH-1:0] exp_tick;
      logic [NCH-1:0] exp_act;
      logic [NCH-1:0] exp_pend;
      exp_tick = '0;
      while (tq.size() > 0 && tq[0].e <= edge_cnt) begin
         exp_tick[tq[0].ch] = 1'b1;
         void'(tq.pop_front());
      end
      for (int i = 0; i < NCH; i++) begin
         exp_act[i]  = m_on[i];
         exp_pend[i] = m_pend[i];
      end
      for (int i = 0; i < NCH; i++) begin
         total++;
         if (tick[i] !== exp_tick[i]) begin
            bad++;
            $display("FAIL tick[%0d] edge %0d: got %b want %b", i, edge_cnt, tick[i], exp_tick[i]);
         end
      end
      total++;
      if (active !== exp_act) begin
         bad++;
         $display("FAIL active edge %0d: got %b want %b", edge_cnt, active, exp_act);
      end
      total++;
      if (pending !== exp_pend) begin
         bad++;
         $display("FAIL pending edge %0d: got %b want %b", edge_cnt, pending, exp_pend);
      end
`ifdef FREQ_DIV_CTRL_CLKOUT_EN
      for (int i = 0; i < NCH; i++) begin
         total++;
         if (clk_div[i] !== m_clk[i]) begin
            bad++;
            $display("FAIL clk_div[%0d] edge %0d: got %b want %b", i, edge_cnt, clk_div[i], m_clk[i]);
         end
      end
`endif
   end

   initial begin
      reset     = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_en    = 1'b0;
      cfg_div   = '0;

      repeat (3) step(0, 0, 0, 0, 0);
      idle(8);

      send(0, 1, 3);
      idle(40);

      idle(5);
      send(0, 1, 5);
      idle(60);

      send(1, 1, 2);
      wait_wrap(1);
      send(1, 1, 1);
      idle(30);

      send(2, 1, 3);
      idle(5);
      for (int k = 0; k < 4 && m_next[2] == n; k++) idle(1);
      send(2, 0, 0);
      idle(20);
      send(2, 1, 3);
      wait_wrap(2);
      send(2, 0, 0);
      idle(20);

      for (int c = 0; c < NCH; c++) send(c, 0, 0);
      send(0, 1, 1);
      send(1, 1, 2);
      send(2, 1, 3);
      send(3, 1, 0);
      idle(17);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      idle(20);
      send(3, 1, 0);
      idle(20);

      send(1, 1, 65535);
      idle(20);

      for (int k = 0; k < 800; k++) begin
         int r;
         int v;
         int ch;
         int en;
         int dv;
         r  = ($urandom_range(0, 299) != 0) ? 1 : 0;
         v  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         ch = int'($urandom_range(0, 3));
         en = ($urandom_range(0, 4) != 0) ? 1 : 0;
         dv = ($urandom_range(0, 15) == 0) ? 65535 : int'($urandom_range(0, 6));
         step(r, v, ch, en, dv);
      end
      idle(30);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Multi-channel tick scheduler that shares one base divide-by-PRE_DIV prescaler among NCH channels.
- Each channel further divides the base tick by a runtime-programmable ratio.
- Reconfiguration goes through a valid/ready handshake. Divisor changes on a running channel are deferred to that channel's next period boundary, so the tick stream never glitches.
- Sits between the control logic and all slow-rate consumers (LED blink, debounce sampling, display scan), replacing per-consumer fixed dividers.

Parameters:
- NCH, 4, number of output channels
- DIV_W, 16, width of the per-channel divisor
- PRE_DIV, 1000, base prescaler ratio (clk cycles per base tick), ≥2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration can be accepted this cycle
- cfg_ch  in  $clog2(NCH)  target channel
- cfg_en  in  1  1 = enable or update channel, 0 = disable channel
- cfg_div  in  DIV_W  divisor in base ticks; 0 is treated as 1
- tick  out  NCH  one-clk pulse per channel period
- active  out  NCH  channel running
- pending  out  NCH  divisor update waiting for boundary

Behaviour:
- Reset (reset==0 at posedge):
  - prescaler counter = 0
  - all channels IDLE, counters = 0
  - tick = 0, active = 0, pending = 0
  - divisor registers = 1
  - cfg_ready = 1 in the first cycle after reset release
- Base prescaler:
  - free-running count 0..PRE_DIV-1, wraps to 0
  - base_tick (internal) is high for the single cycle where count==PRE_DIV-1
  - never stalls, never resynchronised by channel events
- Handshake:
  - accept = cfg_valid & cfg_ready
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch)
  - a request to a pending channel stalls until its update is applied
- Per-channel FSM:
  - IDLE:
    - accept with cfg_en=1: div ← max(cfg_div,1), counter ← 0, go to RUN on the next cycle
    - accept with cfg_en=0: no-op, stay IDLE
  - RUN:
    - counter increments on base_tick
    - on base_tick with counter==div-1: tick pulses the same cycle (registered, so visible the cycle after base_tick) and counter ← 0
    - accept with cfg_en=1: shadow ← max(cfg_div,1), go to PEND
    - accept with cfg_en=0: go to IDLE immediately; counter ← 0; no further ticks
  - PEND:
    - counts with the old div
    - at the wrap event: tick pulses (old period completes), div ← shadow, counter ← 0, go to RUN
    - pending=1 only while in this state
- Latency:
  - enable accepted at cycle T: first tick follows the div-th base_tick strictly after T
  - phase relative to the enable is therefore 1..PRE_DIV cycles, which is intended
- Outputs:
  - tick[i] is a registered pulse, exactly 1 clk wide
  - active[i] = state≠IDLE
- Boundary cases:
  - div=1: tick on every base_tick
  - div = 2^DIV_W-1: counter must not overflow; counter width is DIV_W
  - accept on the same cycle as that channel's wrap: the wrap uses the old div, and the new value applies at the following wrap
  - disable on the same cycle as a wrap: the tick still pulses that cycle, then IDLE
  - reset asserted mid-period: all state clears the next edge; no partial tick
- Channels are independent; simultaneous ticks on several channels are legal.

Optional Feature:
- Macro: FREQ_DIV_CTRL_CLKOUT_EN.
- Defined:
  - adds output clk_div [NCH], a registered level per channel
  - toggles on each tick[i], giving a 50%-duty divided clock of period 2·div·PRE_DIV clk cycles
  - reset value 0
  - forced to 0 on disable
- Undefined: port and logic absent.

Decomposition:
- Package freq_div_pkg:
  - channel state enum {IDLE, RUN, PEND}
  - PRE_DIV_DEFAULT = 1000
  - a function returning max(div,1)
- One natural sub-module, freq_div_chan:
  - per-channel FSM, counter, shadow register
  - inputs: clk, reset, base_tick, load strobe, cfg_en, cfg_div
  - outputs: tick, active, pending, and clk_div when the feature is defined
  - the top holds the prescaler and handshake decode, generate-instantiating NCH copies

Test Plan (PRE_DIV=4 for bench speed):
- Reset for 3 cycles, then release:
  - tick=0, active=0, pending=0, cfg_ready=1
  - base prescaler wraps every 4 clk
- Enable ch0 div=3:
  - ticks every 12 clk
  - each tick exactly 1 clk wide
  - active[0]=1
- Ch0 running div=3, send div=5 mid-period:
  - pending[0]=1 and cfg_ready=0 for cfg_ch=0
  - next tick arrives on the old 12-clk spacing
  - subsequent ticks every 20 clk
  - pending clears at that boundary
- Config accepted on the exact cycle of ch1's wrap (div=2 → 1):
  - the wrap tick occurs
  - the next tick comes 8 clk later, then every 4 clk
- Disable ch2 mid-period, and separately on a wrap cycle:
  - mid-period: no further tick after the accept
  - on a wrap cycle: the final tick is present
  - active[2]=0 in both cases
- Reset asserted mid-period with all 4 channels running at div=1,2,3,0:
  - all outputs 0 the next edge
  - after release nothing ticks until re-enabled
  - div=0 behaves as div=1 (tick every 4 clk)
